// File: rtl/vga_pkg.sv
// Shared VGA raster constants: default 640x480@60 timing,
// derived totals and coordinate widths.
package vga_pkg;

  function automatic int axis_total(
    input int vis,
    input int fp,
    input int sy,
    input int bp
  );
    return vis + fp + sy + bp;
  endfunction

  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FP      = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BP      = 48;

  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FP      = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BP      = 33;

  localparam int H_TOTAL = axis_total(
    DEF_H_VISIBLE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
  localparam int V_TOTAL = axis_total(
    DEF_V_VISIBLE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

  localparam int AXIS_W = 10;
  localparam int COL_W  = 10;
  localparam int ROW_W  = 9;
  localparam int CNT_W  = 8;

endpackage

// File: rtl/sync_axis_cnt.sv
// One raster axis: wrap counter with step enable plus
// visible / sync-window decode of the current count.
module sync_axis_cnt
  import vga_pkg::*;
#(
  parameter int VISIBLE = DEF_H_VISIBLE,
  parameter int FP      = DEF_H_FP,
  parameter int SYNC    = DEF_H_SYNC,
  parameter int BP      = DEF_H_BP,
  parameter int W       = AXIS_W
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         step_i,
  output logic [W-1:0] count_o,
  output logic         wrap_o,
  output logic         visible_o,
  output logic         sync_active_o
);

  localparam int TOTAL = axis_total(VISIBLE, FP, SYNC, BP);

  localparam logic [W-1:0] LAST    = W'(TOTAL - 1);
  localparam logic [W-1:0] VIS_END = W'(VISIBLE);
  localparam logic [W-1:0] SYN_LO  = W'(VISIBLE + FP);
  localparam logic [W-1:0] SYN_HI  = W'(VISIBLE + FP + SYNC);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  assign wrap_o = step_i && (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (step_i) begin
      count_d = wrap_o ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o       = count_q;
  assign visible_o     = count_q < VIS_END;
  assign sync_active_o = (count_q >= SYN_LO)
                      && (count_q < SYN_HI);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: chained h/v axis counters, frame counter
// and a single registered output stage (1-cycle latency).
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_VISIBLE       = DEF_H_VISIBLE,
  parameter int H_FP            = DEF_H_FP,
  parameter int H_SYNC          = DEF_H_SYNC,
  parameter int H_BP            = DEF_H_BP,
  parameter int V_VISIBLE       = DEF_V_VISIBLE,
  parameter int V_FP            = DEF_V_FP,
  parameter int V_SYNC          = DEF_V_SYNC,
  parameter int V_BP            = DEF_V_BP,
  parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic             vga_clk,
  input  logic             reset,
  output logic [COL_W-1:0] col_c,
  output logic [ROW_W-1:0] row_c,
  output logic [CNT_W-1:0] cnt_c,
  output logic             hSync,
  output logic             vSync,
  output logic             de,
  output logic             frame_start,
  output logic             line_start
);

  logic [AXIS_W-1:0] hcnt;
  logic [AXIS_W-1:0] vcnt;
  logic              h_wrap;
  logic              v_wrap;
  logic              h_vis;
  logic              v_vis;
  logic              h_act;
  logic              v_act;

  sync_axis_cnt #(
    .VISIBLE (H_VISIBLE),
    .FP      (H_FP),
    .SYNC    (H_SYNC),
    .BP      (H_BP),
    .W       (AXIS_W)
  ) u_h (
    .clk_i         (vga_clk),
    .rst_i         (reset),
    .step_i        (1'b1),
    .count_o       (hcnt),
    .wrap_o        (h_wrap),
    .visible_o     (h_vis),
    .sync_active_o (h_act)
  );

  sync_axis_cnt #(
    .VISIBLE (V_VISIBLE),
    .FP      (V_FP),
    .SYNC    (V_SYNC),
    .BP      (V_BP),
    .W       (AXIS_W)
  ) u_v (
    .clk_i         (vga_clk),
    .rst_i         (reset),
    .step_i        (h_wrap),
    .count_o       (vcnt),
    .wrap_o        (v_wrap),
    .visible_o     (v_vis),
    .sync_active_o (v_act)
  );

  logic [CNT_W-1:0] fcnt_q, fcnt_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [CNT_W-1:0] cnt_q;
  logic             hs_q, hs_d;
  logic             vs_q, vs_d;
  logic             de_q, de_d;
  logic             fs_q, fs_d;
  logic             ls_q, ls_d;

  assign fcnt_d = v_wrap ? fcnt_q + 1'b1 : fcnt_q;

  // blanking coordinates are forced to zero
  always_comb begin
    de_d = h_vis && v_vis;
    col_d = de_d ? hcnt : '0;
    row_d = de_d ? vcnt[ROW_W-1:0] : '0;
    hs_d = h_act ^ SYNC_ACTIVE_LOW;
    vs_d = v_act ^ SYNC_ACTIVE_LOW;
    ls_d = (hcnt == '0);
    fs_d = ls_d && (vcnt == '0);
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      fcnt_q <= '0;
      col_q  <= '0;
      row_q  <= '0;
      cnt_q  <= '0;
      hs_q   <= SYNC_ACTIVE_LOW;
      vs_q   <= SYNC_ACTIVE_LOW;
      de_q   <= 1'b0;
      fs_q   <= 1'b0;
      ls_q   <= 1'b0;
    end else begin
      fcnt_q <= fcnt_d;
      col_q  <= col_d;
      row_q  <= row_d;
      cnt_q  <= fcnt_q;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      de_q   <= de_d;
      fs_q   <= fs_d;
      ls_q   <= ls_d;
    end
  end

  assign col_c       = col_q;
  assign row_c       = row_q;
  assign cnt_c       = cnt_q;
  assign hSync       = hs_q;
  assign vSync       = vs_q;
  assign de          = de_q;
  assign frame_start = fs_q;
  assign line_start  = ls_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench: three DUTs (default, tiny, tiny with high syncs)
// checked each cycle against a pixel-index arithmetic model.
module tb_vga_timing_gen;

  typedef struct packed {
    logic [9:0] col;
    logic [8:0] row;
    logic [7:0] cnt;
    logic       hs;
    logic       vs;
    logic       de;
    logic       fs;
    logic       ls;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  longint k;
  bit run = 1'b0;
  bit pb  = 1'b0;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  logic [9:0] col0, col1, col2;
  logic [8:0] row0, row1, row2;
  logic [7:0] cnt0, cnt1, cnt2;
  logic hs0, hs1, hs2, vs0, vs1, vs2;
  logic de0, de1, de2, fs0, fs1, fs2, ls0, ls1, ls2;

  vga_timing_gen d0 (
    .vga_clk(clk), .reset(rst),
    .col_c(col0), .row_c(row0), .cnt_c(cnt0),
    .hSync(hs0), .vSync(vs0), .de(de0),
    .frame_start(fs0), .line_start(ls0));

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_VISIBLE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) d1 (
    .vga_clk(clk), .reset(rst),
    .col_c(col1), .row_c(row1), .cnt_c(cnt1),
    .hSync(hs1), .vSync(vs1), .de(de1),
    .frame_start(fs1), .line_start(ls1));

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_VISIBLE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_ACTIVE_LOW(1'b0)
  ) d2 (
    .vga_clk(clk), .reset(rst),
    .col_c(col2), .row_c(row2), .cnt_c(cnt2),
    .hSync(hs2), .vSync(vs2), .de(de2),
    .frame_start(fs2), .line_start(ls2));

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 20)
        $display("FAIL %s got=%0d want=%0d t=%0t",
                 nm, act, exp, $time);
    end
  endtask

  // p = pixel index since reset release
  function automatic obs_t model(
    input int hv, input int hf, input int hsw, input int hb,
    input int vv, input int vf, input int vsw, input int vb,
    input bit pol, input longint p, input bit idle);
    obs_t o;
    longint ht, vt, h, v, f;
    o = '0;
    if (idle) begin
      o.hs = pol;
      o.vs = pol;
      return o;
    end
    ht = hv + hf + hsw + hb;
    vt = vv + vf + vsw + vb;
    h = p % ht;
    v = (p / ht) % vt;
    f = (p / (ht * vt)) % 256;
    o.de  = (h < hv) && (v < vv);
    o.col = o.de ? 10'(h) : 10'd0;
    o.row = o.de ? 9'(v) : 9'd0;
    o.cnt = 8'(f);
    o.hs  = (h >= hv + hf && h < hv + hf + hsw) ? !pol : pol;
    o.vs  = (v >= vv + vf && v < vv + vf + vsw) ? !pol : pol;
    o.ls  = (h == 0);
    o.fs  = (h == 0) && (v == 0);
    return o;
  endfunction

  task automatic cmp(input string nm,
                     input obs_t a, input obs_t e);
    chk({nm, ".col"}, 32'(a.col), 32'(e.col));
    chk({nm, ".row"}, 32'(a.row), 32'(e.row));
    chk({nm, ".cnt"}, 32'(a.cnt), 32'(e.cnt));
    chk({nm, ".hs"},  32'(a.hs),  32'(e.hs));
    chk({nm, ".vs"},  32'(a.vs),  32'(e.vs));
    chk({nm, ".de"},  32'(a.de),  32'(e.de));
    chk({nm, ".fs"},  32'(a.fs),  32'(e.fs));
    chk({nm, ".ls"},  32'(a.ls),  32'(e.ls));
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) k <= 0;
    else     k <= k + 1;
  end

  always @(negedge clk) begin
    if (run) begin
      bit idle;
      idle = rst || (k == 0);
      cmp("d0", {col0, row0, cnt0, hs0, vs0, de0, fs0, ls0},
          model(640, 16, 96, 48, 480, 10, 2, 33, 1'b1, k - 1, idle));
      cmp("d1", {col1, row1, cnt1, hs1, vs1, de1, fs1, ls1},
          model(8, 1, 2, 1, 4, 1, 1, 1, 1'b1, k - 1, idle));
      cmp("d2", {col2, row2, cnt2, hs2, vs2, de2, fs2, ls2},
          model(8, 1, 2, 1, 4, 1, 1, 1, 1'b0, k - 1, idle));
    end
  end

  int de_line = 0;
  int hs_low = 0;
  longint hs_first = -1;
  longint ls_second = -1;
  int nframes = 0;
  longint fs_prev_k = 0;
  logic [7:0] cnt_prev = '0;

  // literal pins for line/frame structure in phase B
  always @(negedge clk) begin
    if (pb && !rst && k >= 1) begin
      if (k <= 800) begin
        if (de0) de_line++;
        if (!hs0) begin
          hs_low++;
          if (hs_first < 0) hs_first = k;
        end
      end
      if (ls0 && k > 1 && ls_second < 0) ls_second = k;
      if (cnt1 !== cnt_prev)
        chk("d1.cnt_only_at_fs", 32'(fs1), 32'd1);
      cnt_prev = cnt1;
      if (fs1) begin
        nframes++;
        if (nframes == 2) begin
          chk("d1.frame_period", 32'(k - fs_prev_k), 32'd84);
          chk("d1.cnt_frame2", 32'(cnt1), 32'd1);
        end
        if (nframes == 256)
          chk("d1.cnt_frame256", 32'(cnt1), 32'd255);
        if (nframes == 257)
          chk("d1.cnt_frame257", 32'(cnt1), 32'd0);
        fs_prev_k = k;
      end
    end
  end

  initial begin
    run = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst.d0.hs", 32'(hs0), 32'd1);
    chk("rst.d2.hs", 32'(hs2), 32'd0);
    chk("rst.d2.vs", 32'(vs2), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("first.de", 32'(de0), 32'd1);
    chk("first.col", 32'(col0), 32'd0);
    chk("first.row", 32'(row0), 32'd0);
    chk("first.cnt", 32'(cnt0), 32'd0);
    chk("first.fs", 32'(fs0), 32'd1);
    chk("first.ls", 32'(ls0), 32'd1);
    // land d1 in hsync+vsync (h=9, v=5 on outputs)
    repeat (321 + $urandom_range(0, 0)) @(posedge clk);
    #2;
    chk("mid.d1.hs", 32'(hs1), 32'd0);
    chk("mid.d1.vs", 32'(vs1), 32'd0);
    chk("mid.d2.hs", 32'(hs2), 32'd1);
    rst = 1'b1;
    #1;
    chk("async.d1.hs", 32'(hs1), 32'd1);
    chk("async.d1.vs", 32'(vs1), 32'd1);
    chk("async.d2.vs", 32'(vs2), 32'd0);
    chk("async.d0.de", 32'(de0), 32'd0);
    chk("async.d0.col", 32'(col0), 32'd0);
    chk("async.d1.cnt", 32'(cnt1), 32'd0);
    chk("async.d0.ls", 32'(ls0), 32'd0);
    repeat ($urandom_range(1, 4)) @(negedge clk);
    pb = 1'b1;
    rst = 1'b0;
    repeat (257 * 84 + 20) @(posedge clk);
    @(negedge clk);
    chk("d0.de_per_line", 32'(de_line), 32'd640);
    chk("d0.hs_low_len", 32'(hs_low), 32'd96);
    chk("d0.hs_start", 32'(hs_first - 1), 32'd656);
    chk("d0.line_period", 32'(ls_second - 1), 32'd800);
    chk("d1.frames_seen", 32'(nframes >= 257), 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
